// File: rtl/vga_register_update_scheduler_if.sv
// Request/response bundle between the PicoBlaze / config-counter side and the
// VGA register update scheduler.
interface vga_register_update_scheduler_if #(
  parameter int unsigned NUM_REGS = 10
);
  logic [7:0]          port_id;
  logic [7:0]          in_dato;
  logic                write_strobe;
  logic [1:0]          config_mode;
  logic                cfg_commit;
  logic [3:0]          cfg_sel;
  logic [7:0]          cfg_data;
  logic [NUM_REGS-1:0] reg_load;
  logic [7:0]          reg_data;
  logic [NUM_REGS-1:0] pending;
  logic                busy;
  logic                overwrite_err;

  modport master (
    output port_id, in_dato, write_strobe, config_mode,
           cfg_commit, cfg_sel, cfg_data,
    input  reg_load, reg_data, pending, busy, overwrite_err
  );

  modport slave (
    input  port_id, in_dato, write_strobe, config_mode,
           cfg_commit, cfg_sel, cfg_data,
    output reg_load, reg_data, pending, busy, overwrite_err
  );
endinterface

// File: rtl/vga_register_update_scheduler.sv
// Buffers display-register writes in shadow slots and replays them during vblank.
// Optional SCHED_BYPASS_EN adds bypass_vblank to issue without waiting for blanking.
module vga_register_update_scheduler #(
  parameter int unsigned NUM_REGS         = 10,
  parameter logic [7:0]  PORT_BASE        = 8'h00,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic vsync,
`ifdef SCHED_BYPASS_EN
  input  logic bypass_vblank,
`endif
  vga_register_update_scheduler_if.slave bus
);

  localparam int unsigned IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  NREG8    = 8'(NUM_REGS);
  localparam logic        VS_IDLE  = VSYNC_ACTIVE_LOW;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state;
  logic [7:0]          shadow [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] reg_load_q;
  logic [7:0]          reg_data_q;
  logic                busy_q;
  logic                err_q;
  logic                vs_meta, vs_sync, vs_prev;

  logic                blank_start;
  logic                go;
  logic [8:0]          pb_diff;
  logic                pb_hit, cfg_hit;
  logic [NUM_REGS-1:0] pb_vec, cf_vec, cap_mask, issue_mask;
  logic [7:0]          cap_data [NUM_REGS];
  logic                found;
  logic [IW-1:0]       sel_idx;
  logic                issue_en;

  assign blank_start = (vs_sync != VS_IDLE) && (vs_prev == VS_IDLE);
`ifdef SCHED_BYPASS_EN
  assign go = blank_start || bypass_vblank;
`else
  assign go = blank_start;
`endif

  always_comb begin
    pb_diff = {1'b0, bus.port_id} - {1'b0, PORT_BASE};
    pb_hit  = bus.write_strobe && !pb_diff[8] && (pb_diff[7:0] < NREG8);
    cfg_hit = bus.cfg_commit && ({4'b0000, bus.cfg_sel} < NREG8);
    pb_vec   = '0;
    cf_vec   = '0;
    cap_mask = '0;
    found    = 1'b0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      pb_vec[i]   = pb_hit && (pb_diff[7:0] == 8'(i));
      cf_vec[i]   = cfg_hit && ({4'b0000, bus.cfg_sel} == 8'(i));
      cap_mask[i] = pb_vec[i] | cf_vec[i];
      // Same-slot collision: config counters win only while user config is active
      cap_data[i] = (cf_vec[i] && (!pb_vec[i] || (bus.config_mode != 2'b00)))
                    ? bus.cfg_data : bus.in_dato;
      if (pending_q[i] && !found) begin
        found   = 1'b1;
        sel_idx = IW'(i);
      end
    end
    issue_en   = found && ((state == SCAN) || go);
    issue_mask = '0;
    if (issue_en) issue_mask[sel_idx] = 1'b1;
  end

  // Outputs are registered: the slot chosen at an edge is presented for the following cycle,
  // so busy/SCAN coincide exactly with cycles carrying a load pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shadow     <= '{default: '0};
      pending_q  <= '0;
      reg_load_q <= '0;
      reg_data_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      vs_meta    <= VS_IDLE;
      vs_sync    <= VS_IDLE;
      vs_prev    <= VS_IDLE;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (cap_mask[i]) shadow[i] <= cap_data[i];
      end
      pending_q <= (pending_q & ~issue_mask) | cap_mask;
      if (|(cap_mask & pending_q & ~issue_mask)) err_q <= 1'b1;
      reg_load_q <= issue_mask;
      reg_data_q <= issue_en ? shadow[sel_idx] : 8'h00;
      busy_q     <= issue_en;
      state      <= issue_en ? SCAN : IDLE;
    end
  end

  assign bus.reg_load      = reg_load_q;
  assign bus.reg_data      = reg_data_q;
  assign bus.pending       = pending_q;
  assign bus.busy          = busy_q;
  assign bus.overwrite_err = err_q;

endmodule
